mem_interface: RTL and testbench

MEM_INTERFACE -- requirements
Module: mem_interface

---
 rtl/mem_interface.sv | 96 +++++++++
 tb/tb_mem_interface.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// Memory interface between the CPU datapath (MAR/MDR) and a single-port memory.
// A single outstanding transaction is allowed; it ends on mem_ack or when the wait counter times out.
module mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mdr_q,
    output logic [ADDR_W-1:0] mar_q,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              err_timeout,
    output logic              err_proto
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       rd_start, wr_start, ack_hit, tmo_hit, proto_hit;

    always_comb begin
        rd_start  = (state == IDLE) && mdr_in && read;
        wr_start  = (state == IDLE) && write && !rd_start;
        ack_hit   = (state != IDLE) && mem_ack;
        // Timeout fires on the edge that would bring the counter to TIMEOUT.
        tmo_hit   = (state != IDLE) && !mem_ack && (cnt == 4'(TIMEOUT - 1));
        proto_hit = ((state == IDLE) && rd_start && write) ||
                    ((state != IDLE) && (mdr_in || read || write));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_start)      state_nxt = RD;
                else if (wr_start) state_nxt = WR;
            end
            RD, WR: begin
                if (ack_hit || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request outputs decode straight from state so an async reset drops them at once.
    assign mem_busy = (state != IDLE);
    assign mem_req  = mem_busy;
    assign mem_we   = (state == WR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mar_q       <= '0;
            mdr_q       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_done    <= 1'b0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            cnt         <= '0;
        end else begin
            mem_done <= ack_hit || tmo_hit;
            if (proto_hit) err_proto <= 1'b1;
            if (tmo_hit)   err_timeout <= 1'b1;
            if (state == IDLE) begin
                cnt <= '0;
                if (mar_in)            mar_q <= bus_in[ADDR_W-1:0];
                if (mdr_in && !read)   mdr_q <= bus_in;
                if (rd_start || wr_start) mem_addr <= mar_q;
                if (wr_start)          mem_wdata <= mdr_q;
            end else begin
                cnt <= cnt + 4'd1;
                if (state == RD) begin
                    if (ack_hit)      mdr_q <= mem_rdata;
                    else if (tmo_hit) mdr_q <= 32'hDEADBEEF;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: read/write, timeout, protocol errors and async reset abort.
module tb_mem_interface;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] bus_in, mem_rdata, mem_wdata, mdr_q;
    logic        mar_in, mdr_in, read, write, mem_ack;
    logic [8:0]  mem_addr, mar_q;
    logic        mem_req, mem_we, mem_busy, mem_done, err_timeout, err_proto;
    int          checks = 0;
    int          errors = 0;
    int          n;

    mem_interface #(.ADDR_W(9), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .mar_in(mar_in),
        .mdr_in(mdr_in), .read(read), .write(write), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mdr_q(mdr_q), .mar_q(mar_q),
        .mem_busy(mem_busy), .mem_done(mem_done), .err_timeout(err_timeout),
        .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; bus_in = '0; mar_in = 0; mdr_in = 0; read = 0; write = 0;
        mem_rdata = '0; mem_ack = 0;
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(mem_busy), 32'd0);
        chk("rst_mar", 32'(mar_q), 32'd0);
        chk("rst_mdr", mdr_q, 32'd0);
        chk("rst_errs", {30'd0, err_timeout, err_proto}, 32'd0);
        reset_n = 1'b1;

        // Read of address 5, ack after 3 cycles
        bus_in = 32'h5; mar_in = 1; step(); mar_in = 0;
        chk("rd_mar", 32'(mar_q), 32'h5);
        mdr_in = 1; read = 1; step(); mdr_in = 0; read = 0;
        chk("rd_req", 32'(mem_req), 32'd1);
        chk("rd_we", 32'(mem_we), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'h5);
        step(); step();
        mem_ack = 1; mem_rdata = 32'h1234ABCD; step(); mem_ack = 0;
        chk("rd_mdr", mdr_q, 32'h1234ABCD);
        chk("rd_done", 32'(mem_done), 32'd1);
        chk("rd_idle", 32'(mem_busy), 32'd0);
        step();
        chk("rd_done_once", 32'(mem_done), 32'd0);

        // Write of 0xCAFEF00D to 0x1F0
        bus_in = 32'h1F0; mar_in = 1; step(); mar_in = 0;
        bus_in = 32'hCAFEF00D; mdr_in = 1; step(); mdr_in = 0;
        chk("wr_mdr_load", mdr_q, 32'hCAFEF00D);
        chk("wr_mdr_noreq", 32'(mem_busy), 32'd0);
        write = 1; step(); write = 0;
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h1F0);
        chk("wr_wdata", mem_wdata, 32'hCAFEF00D);
        step();
        mem_ack = 1; step(); mem_ack = 0;
        chk("wr_done", 32'(mem_done), 32'd1);
        chk("wr_mdr_keep", mdr_q, 32'hCAFEF00D);
        chk("wr_noproto", 32'(err_proto), 32'd0);

        // Read with no ack times out
        mdr_in = 1; read = 1; step(); mdr_in = 0; read = 0;
        n = 0;
        while (mem_busy && n < 40) begin step(); n++; end
        chk("tmo_cycles", 32'(n), 32'd15);
        chk("tmo_mdr", mdr_q, 32'hDEADBEEF);
        chk("tmo_flag", 32'(err_timeout), 32'd1);
        chk("tmo_done", 32'(mem_done), 32'd1);
        step(); step();
        chk("tmo_sticky", 32'(err_timeout), 32'd1);
        chk("tmo_noproto", 32'(err_proto), 32'd0);

        // Read and write on the same edge: read wins
        mdr_in = 1; read = 1; write = 1; step(); mdr_in = 0; read = 0; write = 0;
        chk("rw_busy", 32'(mem_busy), 32'd1);
        chk("rw_we", 32'(mem_we), 32'd0);
        chk("rw_proto", 32'(err_proto), 32'd1);
        mem_ack = 1; mem_rdata = 32'h11112222; step(); mem_ack = 0;
        chk("rw_mdr", mdr_q, 32'h11112222);

        // Mid-cycle reset clears sticky errors
        #2 reset_n = 0; #2 reset_n = 1;
        chk("rst2_errs", {30'd0, err_timeout, err_proto}, 32'd0);

        // Register writes while busy are blocked
        bus_in = 32'h10; mar_in = 1; step(); mar_in = 0;
        mdr_in = 1; read = 1; step(); mdr_in = 0; read = 0;
        bus_in = 32'h77; mar_in = 1; step(); mar_in = 0;
        bus_in = 32'h99; mdr_in = 1; step(); mdr_in = 0;
        chk("busy_mar", 32'(mar_q), 32'h10);
        chk("busy_addr", 32'(mem_addr), 32'h10);
        chk("busy_mdr", mdr_q, 32'd0);
        chk("busy_proto", 32'(err_proto), 32'd1);
        mem_ack = 1; mem_rdata = 32'h55; step(); mem_ack = 0;
        chk("busy_rd_mdr", mdr_q, 32'h55);

        // Reset in the middle of a write
        write = 1; step(); write = 0;
        chk("abort_pre_we", 32'(mem_we), 32'd1);
        #2 reset_n = 0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(mem_busy), 32'd0);
        #2 reset_n = 1;
        mem_ack = 1; mem_rdata = 32'hFFFF0000; step(); mem_ack = 0;
        chk("abort_ack_done", 32'(mem_done), 32'd0);
        chk("abort_ack_mdr", mdr_q, 32'd0);
        chk("abort_ack_idle", 32'(mem_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
